// File: rtl/vram_pkg.sv
// Shared types and defaults for the VRAM write-port arbiter.
// Widths, state encoding and slot-timer defaults live here.
package vram_pkg;

   localparam int VRAM_AW       = 19;
   localparam int VRAM_DW       = 16;
   localparam int DEF_CW        = 20;
   localparam int DEF_PERIOD    = 2**20;
   localparam int DEF_WIN_START = 181440;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWN_A = 2'd1,
      OWN_B = 2'd2
   } state_e;

   typedef enum logic {
      SIDE_A = 1'b0,
      SIDE_B = 1'b1
   } side_e;

endpackage

// File: rtl/vram_arbiter_if.sv
// Requester, window and VRAM write-port signals of the arbiter.
// master = requester side, slave = arbiter side.
interface vram_arbiter_if #(
   parameter int AW = vram_pkg::VRAM_AW,
   parameter int DW = vram_pkg::VRAM_DW
);

   logic          tog;
   logic          a_req;
   logic          a_we;
   logic [AW-1:0] a_addr;
   logic [DW-1:0] a_wdata;
   logic          a_gnt;
   logic          b_req;
   logic          b_we;
   logic [AW-1:0] b_addr;
   logic [DW-1:0] b_wdata;
   logic          b_gnt;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_we;
   logic          mem_valid;
   logic          in_window;

   modport master (
      output tog,
      output a_req, a_we, a_addr, a_wdata,
      output b_req, b_we, b_addr, b_wdata,
      input  a_gnt, b_gnt,
      input  mem_addr, mem_wdata, mem_we, mem_valid,
      input  in_window
   );

   modport slave (
      input  tog,
      input  a_req, a_we, a_addr, a_wdata,
      input  b_req, b_we, b_addr, b_wdata,
      output a_gnt, b_gnt,
      output mem_addr, mem_wdata, mem_we, mem_valid,
      output in_window
   );

endinterface

// File: rtl/vram_slot_timer.sv
// Free-running slot counter that opens requester A's window.
// in_window is combinational so tog takes effect in the same cycle.
module vram_slot_timer
   import vram_pkg::*;
#(
   parameter int CW        = DEF_CW,
   parameter int PERIOD    = DEF_PERIOD,
   parameter int WIN_START = DEF_WIN_START
) (
   input  logic clk,
   input  logic rst,
   input  logic tog,
   output logic in_window
);

   localparam logic [CW-1:0] CNT_LAST  = CW'(PERIOD - 1);
   localparam logic [CW-1:0] CNT_START = CW'(WIN_START);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // next count: wrap to 0 after PERIOD-1
   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_LAST) begin
         cnt_d = '0;
      end
   end

   // counter register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // window is forced closed while reset is asserted
   always_comb begin
      in_window = !rst && tog && (cnt_q >= CNT_START);
   end

endmodule

// File: rtl/vram_arbiter.sv
// Two-requester arbiter for the single VRAM write port.
// Bounded round-robin bursts, registered output stage.
module vram_arbiter
   import vram_pkg::*;
#(
   parameter int AW        = VRAM_AW,
   parameter int DW        = VRAM_DW,
   parameter int CW        = DEF_CW,
   parameter int PERIOD    = DEF_PERIOD,
   parameter int WIN_START = DEF_WIN_START,
   parameter int MAX_BURST = 16
) (
   input  logic          clk,
   input  logic          rst,
   vram_arbiter_if.slave bus
);

   localparam int BW = $clog2(MAX_BURST + 1);
   localparam logic [BW-1:0] BEAT_LAST = BW'(MAX_BURST - 1);

   logic          win;
   logic          e_a;
   logic          e_b;
   logic          gnt_a;
   logic          gnt_b;
   state_e        state_q, state_d;
   side_e         last_q, last_d;
   logic [BW-1:0] beat_q, beat_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic          we_q, we_d;
   logic          valid_q, valid_d;

   vram_slot_timer #(
      .CW        (CW),
      .PERIOD    (PERIOD),
      .WIN_START (WIN_START)
   ) u_timer (
      .clk       (clk),
      .rst       (rst),
      .tog       (bus.tog),
      .in_window (win)
   );

   // eligibility and grants from the registered owner
   always_comb begin
      e_a   = bus.a_req && win;
      e_b   = bus.b_req;
      gnt_a = (state_q == OWN_A) && e_a;
      gnt_b = (state_q == OWN_B) && e_b;
   end

   // ownership FSM: round-robin with a burst cap
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      beat_d  = beat_q;
      unique case (state_q)
         IDLE: begin
            beat_d = '0;
            if (e_a && e_b) begin
               state_d = (last_q == SIDE_A) ? OWN_B : OWN_A;
            end else if (e_a) begin
               state_d = OWN_A;
            end else if (e_b) begin
               state_d = OWN_B;
            end
         end
         OWN_A: begin
            if (!e_a) begin
               last_d  = SIDE_A;
               beat_d  = '0;
               state_d = e_b ? OWN_B : IDLE;
            end else if (beat_q == BEAT_LAST) begin
               beat_d = '0;
               if (e_b) begin
                  last_d  = SIDE_A;
                  state_d = OWN_B;
               end
            end else begin
               beat_d = beat_q + 1'b1;
            end
         end
         OWN_B: begin
            if (!e_b) begin
               last_d  = SIDE_B;
               beat_d  = '0;
               state_d = e_a ? OWN_A : IDLE;
            end else if (beat_q == BEAT_LAST) begin
               beat_d = '0;
               if (e_a) begin
                  last_d  = SIDE_B;
                  state_d = OWN_A;
               end
            end else begin
               beat_d = beat_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            beat_d  = '0;
         end
      endcase
   end

   // output stage: capture the granted beat, else idle with payload held
   always_comb begin
      addr_d  = addr_q;
      wdata_d = wdata_q;
      we_d    = 1'b0;
      valid_d = 1'b0;
      if (gnt_a) begin
         addr_d  = bus.a_addr;
         wdata_d = bus.a_wdata;
         we_d    = bus.a_we;
         valid_d = 1'b1;
      end else if (gnt_b) begin
         addr_d  = bus.b_addr;
         wdata_d = bus.b_wdata;
         we_d    = bus.b_we;
         valid_d = 1'b1;
      end
   end

   // state, burst and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         last_q  <= SIDE_B;
         beat_q  <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         beat_q  <= beat_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
         valid_q <= valid_d;
      end
   end

   // drive the port bundle
   always_comb begin
      bus.a_gnt     = gnt_a;
      bus.b_gnt     = gnt_b;
      bus.mem_addr  = addr_q;
      bus.mem_wdata = wdata_q;
      bus.mem_we    = we_q;
      bus.mem_valid = valid_q;
      bus.in_window = win;
   end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Shares the single VRAM write port between requester A (window-restricted, e.g. the frame blitter) and requester B (always eligible, e.g. the game-logic writer). A free-running slot counter opens A's time window, a three-state FSM gives bounded round-robin bursts, and a registered output stage drives the VRAM port. It sits between the two pixel writers and the VRAM write port; it replaces a fixed time-slot switch and adds grant handshakes.

## Interface
- `AW`, 19: address width.
- `DW`, 16: pixel data width.
- `CW`, 20: slot counter width.
- `PERIOD`, 2**20: slot counter period, in cycles.
- `WIN_START`, 181440: first counter value of A's window.
- `MAX_BURST`, 16: grants per ownership before a forced hand-over.

Ports:
- `clk`  in  1  system clock; every flop on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `tog`  in  1  enables A's window.
- `a_req`, `a_we`  in  1 each  A request and write strobe.
- `a_addr`  in  AW  A address.
- `a_wdata`  in  DW  A data.
- `a_gnt`  out  1  A beat accepted this cycle.
- `b_req`, `b_we`, `b_addr`, `b_wdata`, `b_gnt`: same as A, for B.
- `mem_addr`  out  AW  registered VRAM address.
- `mem_wdata`  out  DW  registered VRAM data.
- `mem_we`  out  1  registered write enable.
- `mem_valid`  out  1  output register holds a beat.
- `in_window`  out  1  `tog && cnt >= WIN_START`.

## Operation
- `cnt` counts 0..PERIOD-1, then wraps to 0.
- `win = tog && cnt >= WIN_START`. This is combinational, so `tog` acts in the same cycle.
- Eligibility: `eA = a_req && win`; `eB = b_req`.
- FSM states: IDLE, OWN_A, OWN_B. `last` flag ∈ {A, B}. `beat` counter width is clog2(MAX_BURST+1).
- IDLE:
  - both eligible → owner is the side ≠ `last`;
  - one eligible → that side;
  - none → stay.
  - `beat` clears on entry to any OWN state.
- Grants are combinational from the registered state:
  - `a_gnt = (state==OWN_A) && eA`;
  - `b_gnt = (state==OWN_B) && eB`.
  - Never both high.
- Each grant increments `beat`.
- OWN_X exits when X is no longer eligible, or when the MAX_BURST-th grant happens. On exit, `last <= X`.
  - Exit goes to the other OWN state if the other side is eligible; otherwise to IDLE.
  - At MAX_BURST with the other side not eligible: stay in OWN_X and clear `beat`.
- Window closes in OWN_A:
  - `a_gnt` drops in that same cycle;
  - next state is OWN_B if `b_req`, else IDLE.
- Requester rule: hold `req`, `addr`, `wdata`, `we` stable until `gnt`. A new beat may be presented in the cycle after `gnt`.
- Output stage, on a grant:
  - `mem_addr` and `mem_wdata` load the granted payload;
  - `mem_we <= x_we`;
  - `mem_valid <= 1`.
- Output stage, with no grant: `mem_valid <= 0`, `mem_we <= 0`, address and data hold.

## Timing
- Reset values: `state`=IDLE, `cnt`=0, `last`=B, `beat`=0, all `mem_*`=0. `a_gnt`, `b_gnt` and `in_window` are 0 while `rst` is high.
- Latency from IDLE: req at cycle n → gnt at n+1 → `mem_*` at n+2.
- Latency within ownership: gnt in the same cycle as req; `mem_*` one cycle later. Sustained rate is 1 beat per cycle.
- Hand-over between owners costs no idle cycle when the other side is already requesting.
- Reset mid-burst: grants drop asynchronously. A beat already in the output register is discarded.
- Counter wrap (PERIOD-1 → 0) closes the window in the cycle `cnt` reads 0.

## Structure
- Shared package `vram_pkg`:
  - AW and DW;
  - the state enum (IDLE, OWN_A, OWN_B);
  - default WIN_START and PERIOD.
- One sub-module, `vram_slot_timer`: holds `cnt` and drives `in_window` from `tog`, PERIOD and WIN_START.
- The FSM and output register stay in `vram_arbiter`.

## Test plan
Bench parameters: PERIOD=64, WIN_START=40, MAX_BURST=4.
- Reset, then B requests continuously with `tog=0`:
  - `b_gnt` every cycle from cycle 1 after IDLE;
  - `mem_addr` follows `b_addr` with 1-cycle lag;
  - `a_gnt` never asserts.
- `a_req` held with `tog=1`, cnt=10: no `a_gnt` until cnt=40. The first `a_gnt` arrives one cycle after `in_window` rises.
- Both requesting continuously inside the window: grants alternate in bursts, first A×4, then B×4, then A×4, …; never both grants in one cycle.
- A owns the bus and the window closes at the wrap to cnt=0: `a_gnt`=0 in that cycle, and `b_gnt`=1 in the next cycle.
- Only B requests for 10 beats inside the window: 10 consecutive grants, with `beat` clearing at 4 and no hand-over.
- Assert `rst` mid-burst, with `a_addr`=0x12345 in flight:
  - grants drop immediately;
  - after release, `mem_valid`=0 and `mem_addr`=0;
  - `last`=B, so A is granted first when both request.
